// File: rtl/memory_rtl_core.sv
// Single-port synchronous word memory with write-priority strobes.
// Every accepted access is acknowledged by a one-cycle response pulse.
module memory_rtl_core #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  response
);

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT =
    (ADDR_WIDTH + 1)'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic                  in_range;

  assign in_range = {1'b0, addr} < MEM_LIMIT;

  // wr dominates rd; out-of-range writes vanish, reads return zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem      <= '{default: '0};
      rdata    <= '0;
      response <= 1'b0;
    end else begin
      response <= wr | rd;
      unique case ({wr, rd})
        2'b10, 2'b11: begin
          if (in_range) mem[addr] <= wdata;
        end
        2'b01: begin
          rdata <= in_range ? mem[addr] : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_rtl_core.sv
// Scoreboard bench for memory_rtl_core: stimulus pushes expected
// responses, a negedge monitor pops them when response is due.
module tb_memory_rtl_core;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int N  = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          response;

  exp_t          exp_q [$];
  exp_t          e;
  logic [DW-1:0] model [N];
  logic [DW-1:0] exp_rdata;
  int            cyc    = 0;
  int            checks = 0;
  int            passes = 0;

  always #5 clk = ~clk;

  memory_rtl_core #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_SIZE  (N)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .response(response)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Monitor: an entry pushed before an edge is due at the following negedge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("response", DW'(response), DW'(1));
        check("rdata", rdata, e.data);
      end else if (response !== 1'b0) begin
        checks++;
        $display("FAIL unexpected_response: got %b expected 0", response);
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < N; i++) model[i] = '0;
    exp_rdata = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
    model[a] = d;
    exp_q.push_back('{data: exp_rdata, cyc: cyc});
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    @(negedge clk);
    wr = 1'b0; rd = 1'b1; addr = a; wdata = '0;
    exp_rdata = model[a];
    exp_q.push_back('{data: exp_rdata, cyc: cyc});
  endtask

  task automatic do_both(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wr = 1'b1; rd = 1'b1; addr = a; wdata = d;
    model[a] = d;
    exp_q.push_back('{data: exp_rdata, cyc: cyc});
  endtask

  task automatic go_idle();
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; wr = 1'b1; rd = 1'b1; addr = 4'd3; wdata = 32'hFFFF_FFFF;
    clear_model();
    repeat (2) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_response", DW'(response), DW'(0));
    reset = 1'b1; wr = 1'b0; rd = 1'b0;

    for (int a = 0; a < N; a++) do_read(AW'(a));
    go_idle();

    do_write(4'd3, 32'hDEAD_BEEF);
    go_idle();
    do_read(4'd3);
    go_idle();
    check("readback_3", rdata, 32'hDEAD_BEEF);

    for (int a = 0; a < N; a++) do_write(AW'(a), DW'(a) * 32'h1111_1111);
    for (int a = 0; a < N; a++) do_read(AW'(a));
    go_idle();
    check("sweep_last", rdata, 32'hFFFF_FFFF);

    do_write(4'd5, 32'h0000_00AA);
    do_read(4'd5);
    do_both(4'd5, 32'h0000_0055);
    go_idle();
    check("both_rdata_held", rdata, 32'h0000_00AA);
    do_read(4'd5);
    go_idle();
    check("after_both", rdata, 32'h0000_0055);

    do_write(4'd9, 32'h1234_5678);
    do_read(4'd9);
    go_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_response", DW'(response), DW'(0));
      check("idle_rdata", rdata, 32'h1234_5678);
    end

    do_write(4'd7, 32'hFFFF_FFFF);
    @(posedge clk);
    #2;
    reset = 1'b0;
    clear_model();
    #1;
    check("midreset_rdata", rdata, 32'h0);
    check("midreset_response", DW'(response), DW'(0));
    @(negedge clk);
    reset = 1'b1; wr = 1'b0; rd = 1'b0;
    do_read(4'd7);
    go_idle();
    check("after_reset_7", rdata, 32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
